// File: rtl/vga_timing_gen_if.sv
// Video raster bundle: syncs, data-enable, coordinates, strobes and frame count.
// The generator drives it through the master modport; sinks read through slave.
interface vga_timing_gen_if #(
    parameter int COORD_W = 12,
    parameter int FRAME_W = 8
);
    logic               o_hsync;
    logic               o_vsync;
    logic               o_de;
    logic [COORD_W-1:0] o_x;
    logic [COORD_W-1:0] o_y;
    logic               o_sof;
    logic               o_eol;
    logic [FRAME_W-1:0] o_frame;

    modport master (
        output o_hsync, o_vsync, o_de, o_x, o_y, o_sof, o_eol, o_frame
    );

    modport slave (
        input  o_hsync, o_vsync, o_de, o_x, o_y, o_sof, o_eol, o_frame
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator in the pixel clock domain.
// Free-running h/v counters are decoded into syncs, data-enable, coordinates
// and strobes, all registered together so every output carries the same
// one-cycle latency. i_run (PLL lock) parks the raster at its origin.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int COORD_W    = 12,
    parameter int FRAME_W    = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_run,
    vga_timing_gen_if.master  vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Refuse to elaborate a mode that cannot be represented.
    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        COORD_W < 1 || FRAME_W < 1) begin : g_bad_param
        $error("vga_timing_gen: every timing and width parameter must be at least 1");
    end
    if ((longint'(H_TOTAL) - 1) >= (longint'(1) << COORD_W) ||
        (longint'(V_TOTAL) - 1) >= (longint'(1) << COORD_W)) begin : g_bad_width
        $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in COORD_W");
    end

    // Decode boundaries, pre-sized to the counter width.
    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT      = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] H_ACT_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] HS_START   = COORD_W'(H_ACTIVE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END     = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_ACT      = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] VS_START   = COORD_W'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END     = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam bit HS_IDLE = !H_SYNC_POL;
    localparam bit VS_IDLE = !V_SYNC_POL;

    // Raster counters and completed-frame count.
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic [FRAME_W-1:0] fcnt_q, fcnt_d;

    // Registered outputs.
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               sof_q, sof_d;
    logic               eol_q, eol_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    logic h_wrap;
    logic v_wrap;
    logic h_vis;
    logic v_vis;
    logic hs_act;
    logic vs_act;

    // Next-state: advance the raster and decode the current (h,v) into outputs.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; otherwise a latch would be inferred.
        h_d     = h_q;
        v_d     = v_q;
        fcnt_d  = fcnt_q;
        hsync_d = HS_IDLE;
        vsync_d = VS_IDLE;
        de_d    = 1'b0;
        x_d     = '0;
        y_d     = '0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        frame_d = frame_q;

        h_wrap  = (h_q == H_LAST);
        v_wrap  = (v_q == V_LAST);
        h_vis   = (h_q < H_ACT);
        v_vis   = (v_q < V_ACT);
        hs_act  = (h_q >= HS_START) && (h_q < HS_END);
        vs_act  = (v_q >= VS_START) && (v_q < VS_END);

        if (i_run) begin
            h_d = h_wrap ? '0 : h_q + COORD_W'(1);
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + COORD_W'(1);
                if (v_wrap) begin
                    fcnt_d = fcnt_q + FRAME_W'(1);
                end
            end

            hsync_d = hs_act ? H_SYNC_POL : HS_IDLE;
            vsync_d = vs_act ? V_SYNC_POL : VS_IDLE;
            de_d    = h_vis && v_vis;
            x_d     = h_q;
            y_d     = v_q;
            sof_d   = (h_q == '0) && (v_q == '0);
            eol_d   = (h_q == H_ACT_LAST) && v_vis;
            frame_d = fcnt_q;
        end else begin
            // Park at the origin; the frame count and o_frame hold.
            h_d = '0;
            v_d = '0;
        end
    end

    // State register: synchronous reset wins over the run gate.
    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values and the outputs stay aligned.
        if (i_reset) begin
            h_q     <= '0;
            v_q     <= '0;
            fcnt_q  <= '0;
            hsync_q <= HS_IDLE;
            vsync_q <= VS_IDLE;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            fcnt_q  <= fcnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            frame_q <= frame_d;
        end
    end

    assign vid.o_hsync = hsync_q;
    assign vid.o_vsync = vsync_q;
    assign vid.o_de    = de_q;
    assign vid.o_x     = x_q;
    assign vid.o_y     = y_q;
    assign vid.o_sof   = sof_q;
    assign vid.o_eol   = eol_q;
    assign vid.o_frame = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 14x8 raster (H 8/2/3/1, V 4/1/2/1).
// Two instances share stimulus: active-low syncs and active-high syncs.
// The driver pushes the hand-derived expected outputs for every edge into a
// queue; a negedge monitor pops and compares against both instances.
module tb_vga_timing_gen;

    localparam int CW = 12;
    localparam int FW = 2;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          sof;
        logic          eol;
        logic [FW-1:0] frame;
    } vid_t;

    logic clk;
    logic i_reset;
    logic i_run;

    vga_timing_gen_if #(.COORD_W(CW), .FRAME_W(FW)) vif0 ();
    vga_timing_gen_if #(.COORD_W(CW), .FRAME_W(FW)) vif1 ();

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
        .COORD_W(CW), .FRAME_W(FW)
    ) dut0 (
        .i_clock (clk),
        .i_reset (i_reset),
        .i_run   (i_run),
        .vid     (vif0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
        .COORD_W(CW), .FRAME_W(FW)
    ) dut1 (
        .i_clock (clk),
        .i_reset (i_reset),
        .i_run   (i_run),
        .vid     (vif1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    vid_t          exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            t_run = 0;        // cycles run since the raster left the origin
    int            base_frames = 0;  // frames completed before the current run stint
    logic [FW-1:0] last_frame = '0;
    int            x_max = 0;
    int            y_max = 0;
    int            sof_seen = 0;
    int            sof_exp = 0;

    task automatic check(input string name, input vid_t act, input vid_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got hs=%b vs=%b de=%b x=%0d y=%0d sof=%b eol=%b fr=%0d want hs=%b vs=%b de=%b x=%0d y=%0d sof=%b eol=%b fr=%0d",
                     name, $time, act.hs, act.vs, act.de, act.x, act.y, act.sof, act.eol, act.frame,
                     exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.sof, exp.eol, exp.frame);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic vid_t idle_vec(input logic [FW-1:0] fr);
        vid_t e;
        e       = '0;
        e.hs    = 1'b1;
        e.vs    = 1'b1;
        e.frame = fr;
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the following edge must show.
    task automatic cyc(input logic run, input logic rst);
        vid_t e;
        int   xx;
        int   yy;
        i_run   = run;
        i_reset = rst;
        if (rst) begin
            t_run       = 0;
            base_frames = 0;
            e           = idle_vec('0);
        end else if (!run) begin
            base_frames += t_run / 112;
            t_run        = 0;
            e            = idle_vec(last_frame);
        end else begin
            xx      = t_run % 14;
            yy      = (t_run / 14) % 8;
            e.x     = CW'(xx);
            e.y     = CW'(yy);
            e.de    = (xx < 8) && (yy < 4);
            e.hs    = !(xx >= 10 && xx <= 12);
            e.vs    = !(yy == 5 || yy == 6);
            e.sof   = (xx == 0) && (yy == 0);
            e.eol   = (xx == 7) && (yy < 4);
            e.frame = FW'((base_frames + t_run / 112) % 4);
            t_run++;
        end
        last_frame = e.frame;
        if (e.sof) sof_exp++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Keep running until the raster position reached so far is state nxt-1.
    task automatic run_until(input int nxt);
        repeat (200) begin
            if (t_run % 112 != nxt) cyc(1'b1, 1'b0);
        end
    endtask

    // Monitor: pop one expectation per edge and compare both polarities.
    vid_t m_exp;
    vid_t m_exp1;
    vid_t m_act0;
    vid_t m_act1;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_act0 = {vif0.o_hsync, vif0.o_vsync, vif0.o_de, vif0.o_x, vif0.o_y,
                      vif0.o_sof, vif0.o_eol, vif0.o_frame};
            m_act1 = {vif1.o_hsync, vif1.o_vsync, vif1.o_de, vif1.o_x, vif1.o_y,
                      vif1.o_sof, vif1.o_eol, vif1.o_frame};
            m_exp1    = m_exp;
            m_exp1.hs = ~m_exp.hs;
            m_exp1.vs = ~m_exp.vs;
            check("raster_pol0", m_act0, m_exp);
            check("raster_pol1", m_act1, m_exp1);
            if (int'(vif0.o_x) > x_max) x_max = int'(vif0.o_x);
            if (int'(vif0.o_y) > y_max) y_max = int'(vif0.o_y);
            if (vif0.o_sof === 1'b1) sof_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_run   = 1'b0;

        // Reset values, then idle with run low.
        repeat (3) cyc(1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0);

        // Five full frames plus the start of a sixth: o_frame 0,1,2,3,0,1.
        repeat (5 * 112 + 3) cyc(1'b1, 1'b0);

        // Drop run right after (x=5,y=2) is shown, hold low, then restart.
        run_until(34);
        repeat (4) cyc(1'b0, 1'b0);
        repeat (50) cyc(1'b1, 1'b0);

        // One-cycle reset while in vsync (line 5), then restart from (0,0).
        run_until(74);
        cyc(1'b1, 1'b1);
        repeat (130) cyc(1'b1, 1'b0);

        i_run = 1'b0;
        repeat (3) @(negedge clk);

        check_int("queue_drained", exp_q.size(), 0);
        check_int("x_max", x_max, 13);
        check_int("y_max", y_max, 7);
        check_int("sof_count", sof_seen, sof_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
